// File: rtl/determine_context_read_write_pkg.sv
// Shared constants for the JPEG-LS context-memory access controller.
package determine_context_read_write_pkg;

  localparam int unsigned Q_LENGTH     = 9;
  localparam int unsigned CONTEXT_RW   = 2;
  localparam int unsigned NUM_CONTEXTS = 365;

endpackage : determine_context_read_write_pkg

// File: rtl/determine_context_read_write.sv
// Decides whether context Q needs a fresh memory read or can use forwarded
// feedback from the update stage, and qualifies context-memory write enables.
module determine_context_read_write
  import determine_context_read_write_pkg::*;
#(
  parameter int unsigned Q_length   = Q_LENGTH,
  parameter int unsigned Context_rw = CONTEXT_RW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_enc,
  input  logic                  start_enc_feedback,
  input  logic [Q_length-1:0]   Q,
  input  logic [Q_length-1:0]   Q_Feedback,
  input  logic [Context_rw-1:0] determineWrite,
  output logic                  read_Context_Memory,
  output logic [Context_rw-1:0] write_Context_Memory
);

  logic start_d1_q, start_d2_q;
  logic start_d1_d, start_d2_d;
  logic fb_valid;

  assign start_d1_d = start_enc;
  assign start_d2_d = start_d1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_d1_q <= 1'b0;
      start_d2_q <= 1'b0;
    end else begin
      start_d1_q <= start_d1_d;
      start_d2_q <= start_d2_d;
    end
  end

  // Feedback Q is only meaningful once start_enc has been high for two prior edges.
  assign fb_valid = start_enc & start_d1_q & start_d2_q;

  always_comb begin
    read_Context_Memory = 1'b0;
    if (start_enc) begin
      read_Context_Memory = ~fb_valid | (Q != Q_Feedback);
    end
  end

  always_comb begin
    write_Context_Memory = '0;
    if (start_enc_feedback) begin
      write_Context_Memory = determineWrite;
    end
  end

endmodule : determine_context_read_write

// File: tb/tb_determine_context_read_write.sv
// Directed table-driven bench for the context-memory access controller.
module tb_determine_context_read_write;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_enc = 1'b0;
  logic       start_enc_feedback = 1'b0;
  logic [8:0] Q = '0;
  logic [8:0] Q_Feedback = '0;
  logic [1:0] determineWrite = '0;
  logic       read_Context_Memory;
  logic [1:0] write_Context_Memory;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic       rst;
    logic       se;
    logic       sf;
    logic [8:0] q;
    logic [8:0] qf;
    logic [1:0] dw;
    logic       er;
    logic [1:0] ew;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  determine_context_read_write #(
    .Q_length  (9),
    .Context_rw(2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_enc           (start_enc),
    .start_enc_feedback  (start_enc_feedback),
    .Q                   (Q),
    .Q_Feedback          (Q_Feedback),
    .determineWrite      (determineWrite),
    .read_Context_Memory (read_Context_Memory),
    .write_Context_Memory(write_Context_Memory)
  );

  function automatic vec_t mk(logic rst, logic se, logic sf, logic [8:0] q,
                              logic [8:0] qf, logic [1:0] dw, logic er, logic [1:0] ew);
    vec_t v;
    v.rst = rst; v.se = se; v.sf = sf; v.q = q; v.qf = qf; v.dw = dw;
    v.er = er; v.ew = ew;
    return v;
  endfunction

  task automatic chk_read(string name, logic exp);
    n_cmp++;
    if (read_Context_Memory !== exp) begin
      n_bad++;
      $display("FAIL %s: read got %b expected %b", name, read_Context_Memory, exp);
    end
  endtask

  task automatic chk_write(string name, logic [1:0] exp);
    n_cmp++;
    if (write_Context_Memory !== exp) begin
      n_bad++;
      $display("FAIL %s: write got %b expected %b", name, write_Context_Memory, exp);
    end
  endtask

  initial begin
    // One row per clock cycle; a posedge follows each check.
    vecs.push_back(mk(1, 0, 0, 9'd0,   9'd0,   2'b00, 0, 2'b00)); // 0 reset, idle
    vecs.push_back(mk(0, 0, 0, 9'd0,   9'd0,   2'b00, 0, 2'b00)); // 1
    vecs.push_back(mk(0, 1, 0, 9'd1,   9'd1,   2'b00, 1, 2'b00)); // 2 warm-up
    vecs.push_back(mk(0, 1, 0, 9'd1,   9'd1,   2'b00, 1, 2'b00)); // 3 warm-up
    vecs.push_back(mk(0, 1, 0, 9'd1,   9'd1,   2'b00, 0, 2'b00)); // 4 bypass
    vecs.push_back(mk(0, 1, 0, 9'd1,   9'd1,   2'b00, 0, 2'b00));
    vecs.push_back(mk(0, 1, 0, 9'd1,   9'd1,   2'b00, 0, 2'b00));
    vecs.push_back(mk(0, 1, 0, 9'd1,   9'd1,   2'b00, 0, 2'b00));
    vecs.push_back(mk(0, 1, 0, 9'd1,   9'd1,   2'b00, 0, 2'b00)); // 8
    vecs.push_back(mk(0, 1, 0, 9'd10,  9'd1,   2'b00, 1, 2'b00)); // 9 mismatch
    vecs.push_back(mk(0, 1, 0, 9'd1,   9'd1,   2'b01, 0, 2'b00)); // 10 write gated
    vecs.push_back(mk(0, 1, 1, 9'd1,   9'd1,   2'b01, 0, 2'b01)); // 11
    vecs.push_back(mk(0, 1, 1, 9'd5,   9'd5,   2'b11, 0, 2'b11)); // 12
    vecs.push_back(mk(1, 1, 1, 9'd5,   9'd5,   2'b11, 1, 2'b11)); // 13 reset mid-run
    vecs.push_back(mk(0, 1, 1, 9'd5,   9'd5,   2'b11, 1, 2'b11)); // 14
    vecs.push_back(mk(0, 1, 1, 9'd5,   9'd5,   2'b11, 1, 2'b11)); // 15
    vecs.push_back(mk(0, 1, 1, 9'd5,   9'd5,   2'b11, 0, 2'b11)); // 16
    vecs.push_back(mk(0, 0, 0, 9'd5,   9'd5,   2'b11, 0, 2'b00)); // 17 drop start
    vecs.push_back(mk(0, 1, 0, 9'd5,   9'd5,   2'b10, 1, 2'b00)); // 18 re-warm
    vecs.push_back(mk(0, 1, 0, 9'd5,   9'd5,   2'b10, 1, 2'b00)); // 19
    vecs.push_back(mk(0, 1, 0, 9'd5,   9'd5,   2'b10, 0, 2'b00)); // 20
    vecs.push_back(mk(0, 1, 0, 9'h1FF, 9'h0FF, 2'b00, 1, 2'b00)); // 21 MSB differs
    vecs.push_back(mk(0, 1, 0, 9'h1FF, 9'h1FF, 2'b00, 0, 2'b00)); // 22 max equal
    vecs.push_back(mk(0, 1, 0, 9'd364, 9'd108, 2'b00, 1, 2'b00)); // 23 low bits equal
    vecs.push_back(mk(0, 0, 1, 9'd3,   9'd3,   2'b10, 0, 2'b10)); // 24 write w/o start

    foreach (vecs[i]) begin
      @(negedge clk);
      reset              = vecs[i].rst;
      start_enc          = vecs[i].se;
      start_enc_feedback = vecs[i].sf;
      Q                  = vecs[i].q;
      Q_Feedback         = vecs[i].qf;
      determineWrite     = vecs[i].dw;
      #2;
      chk_read($sformatf("vec%0d_read", i), vecs[i].er);
      chk_write($sformatf("vec%0d_write", i), vecs[i].ew);
    end

    // Async reset pulse between edges must clear history without a clock edge.
    @(negedge clk);
    start_enc = 1'b1; start_enc_feedback = 1'b0; Q = 9'd7; Q_Feedback = 9'd7;
    repeat (3) @(negedge clk);
    #1 chk_read("steady_bypass", 1'b0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 chk_read("async_pulse_read", 1'b1);
    @(negedge clk);
    #1 chk_read("after_pulse_edge1", 1'b1);
    @(negedge clk);
    #1 chk_read("after_pulse_edge2", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_determine_context_read_write
